fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch front end that drives the PC into the instruction memory and collects the combinationally returned op word. Fetched {pc, op} pairs are buffered in a small in-order queue and handed to decode over a valid/ready handshake. The block handles control-flow redirects from later pipeline stages and stops fetching on a HALT opcode. It sits between imem and the decode stage.

Parameters:
RESET_PC, 16'h0000, fetch address loaded on reset
DEPTH, 2, queue entries (power of two, >=2)
HALT_OP, 16'h0000, op word that stops fetching

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous reset, active-high
pc  out  16  fetch address to imem; equals internal fetch_pc register
op  in  16  instruction word from imem, combinational from pc, same cycle
redirect_valid  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  16  new fetch address
out_valid  out  1  head entry available to decode
out_ready  in  1  decode accepts head entry
out_op  out  16  head entry op
out_pc  out  16  head entry pc
halted  out  1  fetch stopped on HALT_OP

Behaviour:
- State machine: RUN, HALT. Reset -> RUN.
- Reset, sync, highest priority, also mid-operation: fetch_pc<=RESET_PC, queue emptied (count=0, rd/wr pointers 0), state RUN. The cycle after reset: out_valid=0, halted=0, pc=RESET_PC. Entry data contents are don't-care.
- pop = out_valid & out_ready.
- out_valid = (count!=0) & !redirect_valid. It is forced low in a redirect cycle, so no handshake completes in that cycle.
- fetch_en = state==RUN & !redirect_valid & (count<DEPTH | pop). When full, a simultaneous pop and push is allowed.
- On fetch_en: enqueue {pc, op} at tail; fetch_pc<=fetch_pc+1 (16-bit wrap, 16'hFFFF->16'h0000).
- Latency: address X presented in cycle N; with an empty queue, the entry appears with out_valid=1 and out_pc=X in cycle N+1.
- HALT: if fetch_en and op==HALT_OP, the entry is still enqueued (decode sees the halt instruction). fetch_pc is NOT incremented, and state->HALT.
- In HALT: no fetches; pc holds the halt address; halted=1 (registered, state==HALT). The queue continues to drain normally.
- Redirect (any state, lower priority than rst): fetch_pc<=redirect_pc, queue flushed (count=0), state->RUN. No enqueue that cycle. The first fetch of redirect_pc occurs the following cycle.
- No pop: count unchanged by the read side. No fetch: count unchanged by the write side.
- Push only: count+1. Pop only: count-1. Both: count unchanged.
- Output order is strictly FIFO.
- out_op/out_pc are the head entry, driven from storage (no combinational path from op). Their value is don't-care when out_valid=0.
- count never exceeds DEPTH and never underflows. A pop with count==0 is impossible because out_valid=0.

Test Plan:
- Reset, then imem holds LDI/ADD/ADD/ST/JMP at 0..4 with out_ready=1 -> pc 0,1,2,... each cycle. out_valid rises the cycle after reset release+1, with out_pc 0,1,2,3,4 consecutive and out_op matching imem words.
- out_ready=0 from start -> two entries fetched, pc stalls at 2, out_pc holds 0. Raise out_ready -> outputs 0,1,2 in order with no loss or duplicate; pc resumes at 3.
- Queue holding pcs 5,6 and out_ready=1, pulse redirect_valid with redirect_pc=16'h0010 -> out_valid=0 that cycle; next cycle pc=16'h0010, queue empty. The following cycle out_pc=16'h0010; 5 and 6 are never delivered.
- Address 5 holds 16'h0000 -> entry pc=5 delivered, halted=1, pc stays 5, no further entries. Then redirect to 16'h0000 -> halted=0, fetch resumes at 0.
- Redirect to 16'hFFFF with a non-halt op -> next fetch pc=16'h0000, and out_pc sequence is FFFF, 0000.
- Queue full, out_ready=0, rst asserted one cycle -> next cycle out_valid=0, halted=0, pc=RESET_PC. Normal fetch restarts after rst drops.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// Drives the fetch address into imem and captures the combinationally
// returned op word. Each fetched {pc, op} pair is written into a small
// in-order queue, and decode drains that queue over a valid/ready handshake.
// Later stages can redirect fetch, which discards everything in the queue.
// Fetch stops on HALT_OP until the next redirect or reset.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2,
    parameter logic [15:0] HALT_OP  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] pc,
    input  logic [15:0] op,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_op,
    output logic [15:0] out_pc,
    output logic        halted
);

    // Pointer width. DEPTH is a power of two, so the pointers wrap on their own.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Occupancy width. It must be able to hold the value DEPTH itself.
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] op;
    } entry_t;

    entry_t          entries [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [15:0]     fetch_pc;
    state_t          state;

    logic            pop;
    logic            fetch_en;
    logic            is_halt_op;
    logic            has_room;
    entry_t          head;

    // The imem address comes straight from the fetch register.
    assign pc = fetch_pc;

    // A redirect cycle hides the head entry, so decode cannot consume
    // an instruction that is about to be flushed.
    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;

    // When the queue is full, a fetch can still go ahead if the head leaves
    // in the same cycle.
    assign has_room   = (count < CW'(DEPTH)) || pop;
    assign fetch_en   = (state == RUN) && !redirect_valid && has_room;
    assign is_halt_op = (op == HALT_OP);

    // The head entry comes only from storage, so out_op and out_pc have
    // no combinational path from op.
    assign head   = entries[rd_ptr];
    assign out_op = head.op;
    assign out_pc = head.pc;

    // halted is taken directly from the state flop.
    assign halted = (state == HALT);

    // Control path: fetch address, queue pointers, occupancy and run/halt state.
    // NOTE: every register in a clocked block uses <=, so all of them update
    // together from values taken before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            state    <= RUN;
        end else if (redirect_valid) begin
            // Flush the queue and restart fetch. The new address is fetched in the next cycle.
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            state    <= RUN;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (fetch_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                // The halt instruction is still queued so that decode sees it.
                // After that, fetch stays parked on the halt address.
                if (is_halt_op) begin
                    state <= HALT;
                end else begin
                    fetch_pc <= fetch_pc + 16'd1;
                end
            end
            unique case ({fetch_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: write the fetched pair into the tail slot.
    // NOTE: the entry array has no reset. Its contents matter only while
    // count says they are valid, so clearing it would only cost area.
    always_ff @(posedge clk) begin
        if (fetch_en) begin
            entries[wr_ptr] <= {fetch_pc, op};
        end
    end

    // The occupancy can never exceed the queue depth.
    assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));

    // Fetch never happens while halted.
    assert property (@(posedge clk) disable iff (rst) (state == HALT) |-> !fetch_en);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit.
// The bench models imem as a 64K-word array. A queue model follows the
// expected fetch address, the in-flight entries and the halt flag, and it is
// compared with the DUT on every falling edge. Directed sequences also pin
// the key values with hand-computed literals.
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          DEPTH    = 2;
    localparam logic [15:0] HALT_OP  = 16'h0000;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic [15:0] op;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_op;
    logic [15:0] out_pc;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    logic [15:0] imem [65536];
    assign op = imem[pc];

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH),
        .HALT_OP (HALT_OP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .op            (op),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_op        (out_op),
        .out_pc        (out_pc),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected fetch address, queue contents and halt flag.
    typedef struct {
        logic [15:0] pc;
        logic [15:0] op;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc;
    bit          m_halt;
    bit          m_on = 0;

    // Entries the DUT has delivered to decode, in handshake order.
    logic [15:0] dlv_pc[$];
    logic [15:0] dlv_op[$];

    // Compare-and-advance process. Inputs only change just after a rising
    // edge, so the values seen at a falling edge are exactly what the next
    // rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (m_on) begin
                check("pc", pc, m_pc);
                check("halted", halted, m_halt);
                check("out_valid", out_valid, (mq.size() != 0) && !redirect_valid);
                if (mq.size() != 0 && !redirect_valid) begin
                    check("out_pc", out_pc, mq[0].pc);
                    check("out_op", out_op, mq[0].op);
                end
            end
            if (out_valid && out_ready) begin
                dlv_pc.push_back(out_pc);
                dlv_op.push_back(out_op);
            end
            // Advance the model to the state after the next rising edge.
            if (rst) begin
                m_on   = 1;
                m_pc   = RESET_PC;
                m_halt = 0;
                mq.delete();
            end else if (m_on) begin
                if (redirect_valid) begin
                    m_pc   = redirect_pc;
                    m_halt = 0;
                    mq.delete();
                end else begin
                    bit popped;
                    popped = (mq.size() != 0) && out_ready;
                    if (popped) void'(mq.pop_front());
                    if (!m_halt && (mq.size() < DEPTH)) begin
                        mq.push_back('{pc: m_pc, op: imem[m_pc]});
                        if (imem[m_pc] == HALT_OP) m_halt = 1;
                        else m_pc = m_pc + 16'd1;
                    end
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redirect_to(input logic [15:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int hits;
        for (int i = 0; i < 65536; i++) imem[i] = 16'h8000 | 16'(i);
        imem[0] = 16'h1101;  // LDI
        imem[1] = 16'h2212;  // ADD
        imem[2] = 16'h2323;  // ADD
        imem[3] = 16'h3404;  // ST
        imem[4] = 16'h4000;  // JMP
        rst            = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;

        // Reset state, then free-running fetch with decode always ready.
        tick(2);
        check("rst_pc", pc, 16'h0000);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        rst = 1'b0;
        dlv_pc.delete();
        dlv_op.delete();
        tick();
        check("first_valid", out_valid, 1'b1);
        check("first_out_pc", out_pc, 16'h0000);
        check("first_pc", pc, 16'h0001);
        tick(5);
        check("seq_count", dlv_pc.size() >= 5, 1'b1);
        for (int i = 0; i < 5 && i < dlv_pc.size(); i++) begin
            check("seq_pc", dlv_pc[i], 32'(i));
            check("seq_op", dlv_op[i], imem[i]);
        end

        // Back-pressure: two entries are fetched, then the queue stalls.
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick(4);
        check("stall_pc", pc, 16'h0002);
        check("stall_out_pc", out_pc, 16'h0000);
        check("stall_valid", out_valid, 1'b1);
        dlv_pc.delete();
        out_ready = 1'b1;
        tick();
        check("resume_pc", pc, 16'h0003);
        tick(3);
        for (int i = 0; i < 3; i++) check("drain_pc", dlv_pc[i], 32'(i));

        // A redirect flushes queued entries 5 and 6 without delivering them.
        out_ready = 1'b0;
        redirect_to(16'h0005);
        tick(3);
        check("full_pc", pc, 16'h0007);
        check("full_head", out_pc, 16'h0005);
        dlv_pc.delete();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        #1;
        check("redir_valid_low", out_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        check("redir_pc", pc, 16'h0010);
        check("redir_empty", out_valid, 1'b0);
        tick();
        check("redir_first_valid", out_valid, 1'b1);
        check("redir_first_pc", out_pc, 16'h0010);
        hits = 0;
        foreach (dlv_pc[i]) if (dlv_pc[i] == 16'h0005 || dlv_pc[i] == 16'h0006) hits++;
        check("flushed_not_delivered", hits, 0);

        // Halt on address 5. The halt entry is delivered, then fetch stops.
        imem[5] = HALT_OP;
        dlv_pc.delete();
        redirect_to(16'h0003);
        tick(3);
        check("halt_flag", halted, 1'b1);
        check("halt_pc", pc, 16'h0005);
        check("halt_head", out_pc, 16'h0005);
        tick(3);
        check("halt_drained", out_valid, 1'b0);
        check("halt_pc_hold", pc, 16'h0005);
        check("halt_dlv_n", dlv_pc.size(), 3);
        check("halt_dlv_last", dlv_pc[2], 16'h0005);
        redirect_to(16'h0000);
        check("unhalt_flag", halted, 1'b0);
        check("unhalt_pc", pc, 16'h0000);
        tick();
        check("unhalt_out_pc", out_pc, 16'h0000);
        check("unhalt_next_pc", pc, 16'h0001);

        // The fetch address wraps from FFFF to 0000.
        redirect_to(16'hFFFF);
        check("wrap_pc0", pc, 16'hFFFF);
        tick();
        check("wrap_pc1", pc, 16'h0000);
        check("wrap_out0", out_pc, 16'hFFFF);
        tick();
        check("wrap_out1", out_pc, 16'h0000);

        // Reset while the queue is full.
        out_ready = 1'b0;
        redirect_to(16'h0020);
        tick(3);
        check("prerst_pc", pc, 16'h0022);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_halted", halted, 1'b0);
        check("midrst_pc", pc, RESET_PC);
        tick(2);
        check("postrst_valid", out_valid, 1'b1);
        check("postrst_out_pc", out_pc, 16'h0000);

        // Reset while halted clears the halt.
        out_ready = 1'b1;
        redirect_to(16'h0005);
        tick(2);
        check("halt2_flag", halted, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("halt2_rst", halted, 1'b0);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
